// File: rtl/multi_cycle_clock_mips_if.sv
// Load/status bus of the multi-cycle MIPS core: instruction load port plus retire/halt status.
// Latency: pure wiring, no storage.
// Backpressure: none; WE is accepted every cycle, status outputs are free-running.
//
// Signals:
//   WE, W_Ins          load enable and instruction word (driven by master)
//   PC, Result, Wdata  program counter, last EX result, last writeback value (driven by slave)
//   Retire, Halt, Illegal  retire pulse and sticky halt status (driven by slave)
// Modports: master = bench / board top, slave = core.
interface multi_cycle_clock_mips_if;
    logic        WE;
    logic [31:0] W_Ins;
    logic [31:0] PC;
    logic [31:0] Result;
    logic [31:0] Wdata;
    logic        Retire;
    logic        Halt;
    logic        Illegal;

    modport master (
        output WE, W_Ins,
        input  PC, Result, Wdata, Retire, Halt, Illegal
    );

    modport slave (
        input  WE, W_Ins,
        output PC, Result, Wdata, Retire, Halt, Illegal
    );
endinterface

// File: rtl/multi_cycle_clock_mips.sv
// Multi-cycle MIPS subset core: one shared datapath sequenced by an FSM, imem loaded via WE/W_Ins.
// Latency: j 2, beq 3, R-type/addi/sw 4, lw 5 clocks from fetch to retire.
// Backpressure: none; WE preempts any state (instruction abandoned), Halt freezes until WE or RST.
//
// Ports: CLK, RST (async active-high) plain; bus (slave modport) carries WE/W_Ins load port and
// PC/Result/Wdata/Retire/Halt/Illegal status.
module multi_cycle_clock_mips #(
    parameter int          IMEM_DEPTH = 256,
    parameter int          DMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                     CLK,
    input  logic                     RST,
    multi_cycle_clock_mips_if.slave  bus
);
    localparam int IW = $clog2(IMEM_DEPTH);
    localparam int DW = $clog2(DMEM_DEPTH);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {S_LOAD, S_IF, S_ID, S_EX, S_MA, S_WB, S_HALT} state_t;

    state_t state_q, state_d;

    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] dmem [DMEM_DEPTH];
    logic [31:0] rf   [32];

    logic [31:0]   pc_q, ir_q, a_q, b_q, imm_q, mdr_q, result_q, wdata_q;
    logic          halt_q, illegal_q;
    logic [IW-1:0] ptr_q;

    // Decode fields, taken from IR which stays stable from S_ID to the final state.
    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd, shamt;
    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign shamt  = ir_q[10:6];
    assign funct  = ir_q[5:0];

    logic is_rtype, is_j, is_beq, is_addi, is_lw, is_sw, legal;
    assign is_rtype = (opcode == OP_RTYPE);
    assign is_j     = (opcode == OP_J);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_addi  = (opcode == OP_ADDI);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);

    always_comb begin
        legal = is_j || is_beq || is_addi || is_lw || is_sw;
        if (is_rtype) begin
            case (funct)
                FN_SLL, FN_SRL, FN_ADD, FN_SUB,
                FN_AND, FN_OR, FN_SLT: legal = 1'b1;
                default:               legal = 1'b0;
            endcase
        end
    end

    // ALU: addi/lw/sw add the immediate, beq subtracts so Result shows A-B.
    logic [31:0] alu_y;
    always_comb begin
        alu_y = a_q + imm_q;
        if (is_beq) begin
            alu_y = a_q - b_q;
        end else if (is_rtype) begin
            case (funct)
                FN_SUB:  alu_y = a_q - b_q;
                FN_AND:  alu_y = a_q & b_q;
                FN_OR:   alu_y = a_q | b_q;
                FN_SLT:  alu_y = {31'b0, ($signed(a_q) < $signed(b_q))};
                FN_SLL:  alu_y = b_q << shamt;
                FN_SRL:  alu_y = b_q >> shamt;
                default: alu_y = a_q + b_q;
            endcase
        end
    end

    logic [4:0]  wb_dst;
    logic [31:0] wb_val;
    assign wb_dst = is_rtype ? rd : rt;
    assign wb_val = is_lw ? mdr_q : result_q;

    logic [IW-1:0] fetch_idx, load_idx;
    logic [DW-1:0] dmem_idx;
    assign fetch_idx = pc_q[IW+1:2];
    assign dmem_idx  = result_q[DW+1:2];
    // The first WE cycle outside S_LOAD restarts the load at word 0.
    assign load_idx  = (state_q == S_LOAD) ? ptr_q : '0;

    // Next state and retire pulse.
    logic retire;
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_LOAD: state_d = S_IF;
            S_IF:   state_d = S_ID;
            S_ID: begin
                if (!legal) begin
                    state_d = S_HALT;
                end else if (is_j) begin
                    state_d = S_IF;
                    retire  = 1'b1;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                if (is_beq) begin
                    state_d = S_IF;
                    retire  = 1'b1;
                end else if (is_lw || is_sw) begin
                    state_d = S_MA;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MA: begin
                if (is_sw) begin
                    state_d = S_IF;
                    retire  = 1'b1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                state_d = S_IF;
                retire  = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
        // A load request abandons whatever is in flight.
        if (bus.WE) begin
            state_d = S_LOAD;
            retire  = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= S_IF;
        else     state_q <= state_d;
    end

    // Storage arrays are never cleared; RST gating keeps a reset edge from committing a write.
    logic imem_we, dmem_we, rf_we;
    assign imem_we = bus.WE && !RST;
    assign dmem_we = (state_q == S_MA) && is_sw && !bus.WE && !RST;
    assign rf_we   = (state_q == S_WB) && (wb_dst != 5'd0) && !bus.WE && !RST;

    always_ff @(posedge CLK) begin
        if (imem_we) imem[load_idx] <= bus.W_Ins;
        if (dmem_we) dmem[dmem_idx] <= b_q;
        if (rf_we)   rf[wb_dst]     <= wb_val;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            mdr_q     <= '0;
            result_q  <= '0;
            wdata_q   <= '0;
            halt_q    <= 1'b0;
            illegal_q <= 1'b0;
            ptr_q     <= '0;
        end else if (bus.WE) begin
            ptr_q     <= load_idx + 1'b1;
            halt_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    pc_q      <= RESET_PC;
                    halt_q    <= 1'b0;
                    illegal_q <= 1'b0;
                    ptr_q     <= '0;
                end
                S_IF: begin
                    ir_q <= imem[fetch_idx];
                    pc_q <= pc_q + 32'd4;
                end
                S_ID: begin
                    a_q   <= (rs == 5'd0) ? 32'd0 : rf[rs];
                    b_q   <= (rt == 5'd0) ? 32'd0 : rf[rt];
                    imm_q <= {{16{ir_q[15]}}, ir_q[15:0]};
                    if (!legal) begin
                        halt_q    <= 1'b1;
                        illegal_q <= 1'b1;
                    end else if (is_j) begin
                        // pc_q already holds PC+4 here.
                        pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
                    end
                end
                S_EX: begin
                    result_q <= alu_y;
                    if (is_beq && (a_q == b_q)) pc_q <= pc_q + {imm_q[29:0], 2'b00};
                end
                S_MA: begin
                    if (is_lw) mdr_q <= dmem[dmem_idx];
                end
                S_WB: begin
                    wdata_q <= wb_val;
                end
                default: ;
            endcase
        end
    end

    assign bus.PC      = pc_q;
    assign bus.Result  = result_q;
    assign bus.Wdata   = wdata_q;
    assign bus.Retire  = retire;
    assign bus.Halt    = halt_q;
    assign bus.Illegal = illegal_q;
endmodule

// File: tb/tb_multi_cycle_clock_mips.sv
// Self-checking bench for multi_cycle_clock_mips against an instruction-level reference model.
// Latency: measured per instruction from fetch to Retire.
// Backpressure: exercised through WE loads that preempt running or halted code.
module tb_multi_cycle_clock_mips;
    logic CLK = 1'b0;
    logic RST = 1'b1;

    multi_cycle_clock_mips_if bus();

    multi_cycle_clock_mips dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Architectural model state.
    logic [31:0] m_rf   [32];
    logic [31:0] m_dmem [256];
    logic [31:0] m_imem [256];
    logic [31:0] m_pc, exp_result, exp_wdata;
    logic [31:0] prog [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] target);
        return {6'h02, target};
    endfunction

    function automatic logic [31:0] rd_reg(input logic [4:0] r);
        return (r == 5'd0) ? 32'd0 : m_rf[r];
    endfunction

    task automatic wr_reg(input logic [4:0] r, input logic [31:0] v);
        exp_wdata = v;
        if (r != 5'd0) m_rf[r] = v;
    endtask

    // Executes one instruction at ISA level and returns its expected clock count.
    task automatic model_step(input logic [31:0] ins, output int lat);
        logic [31:0] a, b, imm, npc, addr, v;
        a   = rd_reg(ins[25:21]);
        b   = rd_reg(ins[20:16]);
        imm = {{16{ins[15]}}, ins[15:0]};
        npc = m_pc + 32'd4;
        lat = 0;
        case (ins[31:26])
            6'h00: begin
                case (ins[5:0])
                    6'h20:   v = a + b;
                    6'h22:   v = a - b;
                    6'h24:   v = a & b;
                    6'h25:   v = a | b;
                    6'h2A:   v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h00:   v = b << ins[10:6];
                    default: v = b >> ins[10:6];
                endcase
                exp_result = v;
                wr_reg(ins[15:11], v);
                lat = 4;
            end
            6'h08: begin
                v = a + imm;
                exp_result = v;
                wr_reg(ins[20:16], v);
                lat = 4;
            end
            6'h23: begin
                addr = a + imm;
                exp_result = addr;
                wr_reg(ins[20:16], m_dmem[addr[9:2]]);
                lat = 5;
            end
            6'h2B: begin
                addr = a + imm;
                exp_result = addr;
                m_dmem[addr[9:2]] = b;
                lat = 4;
            end
            6'h04: begin
                exp_result = a - b;
                if (a == b) npc = npc + (imm << 2);
                lat = 3;
            end
            default: begin
                npc = {npc[31:28], ins[25:0], 2'b00};
                lat = 2;
            end
        endcase
        m_pc = npc;
    endtask

    // Loads prog through WE, ends just after the core leaves the load state.
    task automatic load_prog();
        @(negedge CLK);
        foreach (prog[i]) begin
            bus.WE    = 1'b1;
            bus.W_Ins = prog[i];
            m_imem[i] = prog[i];
            @(negedge CLK);
        end
        bus.WE = 1'b0;
        @(posedge CLK);
        #1;
        m_pc = 32'd0;
    endtask

    // Counts clocks from fetch until Retire, then steps past the final state.
    task automatic run_one(output int lat);
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!bus.Retire && lat < 20);
        @(posedge CLK);
        #1;
    endtask

    task automatic run_check(input string tag, output int lat);
        logic [31:0] ins;
        int elat;
        ins = m_imem[m_pc[9:2]];
        model_step(ins, elat);
        run_one(lat);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_pc"}, bus.PC, m_pc);
        check({tag, "_result"}, bus.Result, exp_result);
        check({tag, "_wdata"}, bus.Wdata, exp_wdata);
    endtask

    initial begin
        int lat;
        logic [5:0] fns [7];
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
        bus.WE    = 1'b0;
        bus.W_Ins = 32'd0;
        m_rf[0]   = 32'd0;
        exp_result = 32'd0;
        exp_wdata  = 32'd0;
        m_pc       = 32'd0;

        // Reset state.
        repeat (2) @(posedge CLK);
        #1;
        check("rst_pc", bus.PC, 32'd0);
        check("rst_result", bus.Result, 32'd0);
        check("rst_wdata", bus.Wdata, 32'd0);
        check("rst_retire", {31'd0, bus.Retire}, 32'd0);
        check("rst_halt", {31'd0, bus.Halt}, 32'd0);
        check("rst_illegal", {31'd0, bus.Illegal}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // addi/addi/add chain.
        prog = '{enc_i(6'h08, 0, 1, 16'd5), enc_i(6'h08, 1, 2, 16'hFFF9), enc_r(6'h20, 1, 2, 3, 0)};
        load_prog();
        run_check("trio0", lat);
        check("trio0_wd", bus.Wdata, 32'd5);
        check("trio0_lat4", lat, 32'd4);
        run_check("trio1", lat);
        check("trio1_wd", bus.Wdata, 32'hFFFF_FFFE);
        run_check("trio2", lat);
        check("trio2_wd", bus.Wdata, 32'd3);

        // Store then load back.
        prog = '{enc_i(6'h08, 0, 1, 16'h1234), enc_i(6'h2B, 0, 1, 16'd8), enc_i(6'h23, 0, 4, 16'd8)};
        load_prog();
        run_check("swlw0", lat);
        run_check("swlw_sw", lat);
        run_check("swlw_lw", lat);
        check("lw_lat5", lat, 32'd5);
        check("lw_wd", bus.Wdata, 32'h1234);

        // Branch to itself.
        prog = '{enc_i(6'h04, 0, 0, 16'hFFFF)};
        load_prog();
        for (int k = 0; k < 2; k++) begin
            run_check("beq", lat);
            check("beq_lat3", lat, 32'd3);
            check("beq_pc", bus.PC, 32'd0);
            check("beq_result", bus.Result, 32'd0);
        end

        // Jump from 0x10 to 0x100.
        prog = '{enc_i(6'h08, 0, 5, 16'd1), enc_i(6'h08, 0, 5, 16'd1),
                 enc_i(6'h08, 0, 5, 16'd1), enc_i(6'h08, 0, 5, 16'd1), enc_j(26'h40)};
        load_prog();
        for (int k = 0; k < 4; k++) run_check("jpre", lat);
        run_check("j", lat);
        check("j_lat2", lat, 32'd2);
        check("j_pc", bus.PC, 32'h100);
        check("j_wdata_kept", bus.Wdata, 32'd1);

        // Illegal opcode halts; a load restarts.
        prog = '{32'hFC00_0000};
        load_prog();
        @(negedge CLK);
        check("ill_if_retire", {31'd0, bus.Retire}, 32'd0);
        @(negedge CLK);
        check("ill_id_retire", {31'd0, bus.Retire}, 32'd0);
        @(posedge CLK);
        #1;
        check("ill_halt", {31'd0, bus.Halt}, 32'd1);
        check("ill_illegal", {31'd0, bus.Illegal}, 32'd1);
        repeat (3) @(negedge CLK);
        check("ill_hold_retire", {31'd0, bus.Retire}, 32'd0);
        check("ill_hold_pc", bus.PC, 32'd4);
        check("ill_hold_halt", {31'd0, bus.Halt}, 32'd1);
        prog = '{enc_i(6'h08, 0, 1, 16'd5), enc_i(6'h08, 1, 2, 16'hFFF9), enc_r(6'h20, 1, 2, 3, 0)};
        load_prog();
        check("reload_halt", {31'd0, bus.Halt}, 32'd0);
        check("reload_illegal", {31'd0, bus.Illegal}, 32'd0);
        check("reload_pc", bus.PC, 32'd0);
        for (int k = 0; k < 3; k++) run_check("reload", lat);

        // Reset during the memory access of a store.
        prog = '{enc_i(6'h08, 0, 1, 16'h0077), enc_i(6'h2B, 0, 1, 16'd12)};
        load_prog();
        run_check("seed0", lat);
        run_check("seed1", lat);
        prog = '{enc_i(6'h08, 0, 1, 16'h0055), enc_i(6'h2B, 0, 1, 16'd12)};
        load_prog();
        run_check("rstsw_addi", lat);
        repeat (4) @(negedge CLK);      // IF, ID, EX, MA of the store
        RST = 1'b1;
        #1;
        check("rstma_pc", bus.PC, 32'd0);
        check("rstma_result", bus.Result, 32'd0);
        check("rstma_wdata", bus.Wdata, 32'd0);
        check("rstma_retire", {31'd0, bus.Retire}, 32'd0);
        check("rstma_halt", {31'd0, bus.Halt}, 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        exp_result = 32'd0;
        exp_wdata  = 32'd0;
        prog = '{enc_i(6'h23, 0, 5, 16'd12)};
        load_prog();
        run_check("rstma_lw", lat);
        check("rstma_dmem_kept", bus.Wdata, 32'h77);

        // Random program: register/memory preamble, then random mix.
        prog.delete();
        for (int k = 1; k < 8; k++) prog.push_back(enc_i(6'h08, 0, 5'(k), 16'($urandom)));
        for (int k = 0; k < 8; k++) prog.push_back(enc_i(6'h2B, 0, 5'(k), 16'(4 * k)));
        for (int i = 0; i < 40; i++) begin
            logic [4:0] ra, rb, rc;
            int idx;
            idx = prog.size();
            ra = 5'($urandom_range(0, 7));
            rb = 5'($urandom_range(0, 7));
            rc = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0, 1: prog.push_back(enc_r(fns[$urandom_range(0, 6)], ra, rb, rc, 5'($urandom)));
                2:    prog.push_back(enc_i(6'h08, ra, rb, 16'($urandom)));
                3:    prog.push_back(enc_i($urandom_range(0, 1) ? 6'h23 : 6'h2B, 0, rb,
                                           16'(4 * $urandom_range(0, 7))));
                4:    prog.push_back(enc_i(6'h04, ra, $urandom_range(0, 1) ? ra : rb,
                                           16'($urandom_range(0, 2))));
                default: prog.push_back(enc_j(26'(idx + 1 + $urandom_range(0, 2))));
            endcase
        end
        load_prog();
        for (int s = 0; s < 300 && m_pc < 32'(4 * prog.size()); s++) run_check("rnd", lat);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
